// File: rtl/pc_stack_unit.sv
// Program-counter and branch unit: sequential fetch, conditional absolute or
// PC-relative jumps, CALL/RET through a small return-address stack, stall
// and sticky stack overflow/underflow flags.
module pc_stack_unit #(
  parameter int unsigned    AW         = 8,
  parameter int unsigned    DEPTH      = 4,
  parameter logic [AW-1:0]  RESET_ADDR = '0
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         EN,
  input  logic                         JMP_INST,
  input  logic                         CALL_INST,
  input  logic                         RET_INST,
  input  logic                         REL,
  input  logic [3:0]                   OP,
  input  logic [7:0]                   FLAGS,
  input  logic [AW-1:0]                TARGET,
  output logic [AW-1:0]                ADDR,
  output logic [$clog2(DEPTH+1)-1:0]   SP,
  output logic                         STK_FULL,
  output logic                         STK_EMPTY,
  output logic                         OVF_ERR,
  output logic                         UNF_ERR
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]  addr_q;
  logic [SPW-1:0] sp_q;
  logic           ovf_q;
  logic           unf_q;
  logic [AW-1:0]  stack_mem [DEPTH];

  logic [AW-1:0]  nxt;
  logic [AW-1:0]  tgt;
  logic           cond;
  logic           full;
  logic           empty;
  logic [IW-1:0]  top_idx;
  logic [IW-1:0]  push_idx;
  logic           push_ok;

  // Candidate next addresses, jump condition and stack pointer decode
  always_comb begin
    nxt      = addr_q + 1'b1;
    // Adding an AW-bit two's complement offset mod 2^AW equals sign extension
    tgt      = REL ? (addr_q + TARGET) : TARGET;
    cond     = (FLAGS[OP[2:0]] == OP[3]);
    full     = (sp_q == SPW'(DEPTH));
    empty    = (sp_q == '0);
    top_idx  = IW'(sp_q - 1'b1);
    push_idx = IW'(sp_q);
    push_ok  = RST_N & EN & ~RET_INST & CALL_INST & ~full;
  end

  // Return-address storage, written only on a successful CALL
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      stack_mem[push_idx] <= nxt;
    end
  end

  // PC, stack pointer and sticky error flags with RET > CALL > JMP priority
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      addr_q <= RESET_ADDR;
      sp_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (EN) begin
      if (RET_INST) begin
        if (!empty) begin
          addr_q <= stack_mem[top_idx];
          sp_q   <= sp_q - 1'b1;
        end else begin
          unf_q  <= 1'b1;
          addr_q <= nxt;
        end
      end else if (CALL_INST) begin
        if (!full) begin
          addr_q <= tgt;
          sp_q   <= sp_q + 1'b1;
        end else begin
          ovf_q  <= 1'b1;
          addr_q <= nxt;
        end
      end else if (JMP_INST) begin
        addr_q <= cond ? tgt : nxt;
      end else begin
        addr_q <= nxt;
      end
    end
  end

  assign ADDR      = addr_q;
  assign SP        = sp_q;
  assign STK_FULL  = full;
  assign STK_EMPTY = empty;
  assign OVF_ERR   = ovf_q;
  assign UNF_ERR   = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit (AW=8, DEPTH=4, RESET_ADDR=0xF0): hand-written
// vector table, directed multi-cycle sequences and a random run against a
// queue-based reference model.
module tb_pc_stack_unit;

  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int RADDR = 'hF0;

  logic       CLK = 1'b0;
  logic       RST_N, EN, JMP_INST, CALL_INST, RET_INST, REL;
  logic [3:0] OP;
  logic [7:0] FLAGS;
  logic [7:0] TARGET;
  logic [7:0] ADDR;
  logic [2:0] SP;
  logic       STK_FULL, STK_EMPTY, OVF_ERR, UNF_ERR;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int m_addr;
  int m_stack[$];
  int m_ovf;
  int m_unf;

  pc_stack_unit #(.AW(AW), .DEPTH(DEPTH), .RESET_ADDR(8'hF0)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .JMP_INST(JMP_INST),
    .CALL_INST(CALL_INST), .RET_INST(RET_INST), .REL(REL), .OP(OP),
    .FLAGS(FLAGS), .TARGET(TARGET), .ADDR(ADDR), .SP(SP),
    .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY), .OVF_ERR(OVF_ERR),
    .UNF_ERR(UNF_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst_n, en, jmp, call, ret, rel;
    logic [3:0] op;
    logic [7:0] flags, target;
    int         e_addr, e_sp, e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic void check(string name, int got, int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endfunction

  // Spec rules in plain integer arithmetic; the stack is a queue
  function automatic void model_step();
    int nxt, tgt, off, cond;
    if (!RST_N) begin
      m_addr = RADDR; m_stack.delete(); m_ovf = 0; m_unf = 0;
      return;
    end
    if (!EN) return;
    nxt  = (m_addr + 1) % 256;
    off  = (TARGET >= 128) ? int'(TARGET) - 256 : int'(TARGET);
    tgt  = REL ? ((m_addr + off + 256) % 256) : int'(TARGET);
    cond = (((FLAGS >> OP[2:0]) & 8'd1) == {7'd0, OP[3]}) ? 1 : 0;
    if (RET_INST) begin
      if (m_stack.size() > 0) m_addr = m_stack.pop_back();
      else begin m_unf = 1; m_addr = nxt; end
    end else if (CALL_INST) begin
      if (m_stack.size() < DEPTH) begin m_stack.push_back(nxt); m_addr = tgt; end
      else begin m_ovf = 1; m_addr = nxt; end
    end else if (JMP_INST) begin
      m_addr = cond ? tgt : nxt;
    end else begin
      m_addr = nxt;
    end
  endfunction

  task automatic drive(input logic rst_n, en, jmp, call, ret, rel,
                       input logic [3:0] op, input logic [7:0] flags, target);
    @(negedge CLK);
    RST_N = rst_n; EN = en; JMP_INST = jmp; CALL_INST = call; RET_INST = ret;
    REL = rel; OP = op; FLAGS = flags; TARGET = target;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic check_exp(string tag, int a, int s, int o, int u);
    check({tag, ".addr"},  int'(ADDR), a);
    check({tag, ".sp"},    int'(SP), s);
    check({tag, ".full"},  int'(STK_FULL), (s == DEPTH) ? 1 : 0);
    check({tag, ".empty"}, int'(STK_EMPTY), (s == 0) ? 1 : 0);
    check({tag, ".ovf"},   int'(OVF_ERR), o);
    check({tag, ".unf"},   int'(UNF_ERR), u);
  endtask

  task automatic check_model(string tag);
    check_exp(tag, m_addr, m_stack.size(), m_ovf, m_unf);
  endtask

  // always-taken absolute jump: FLAGS[7]==0 with OP=0111, FLAGS=0
  task automatic go_to(input logic [7:0] a);
    drive(1, 1, 1, 0, 0, 0, 4'b0111, 8'h00, a);
  endtask

  function automatic void add(logic rst_n, en, jmp, call, ret, rel,
                              logic [3:0] op, logic [7:0] flags, target,
                              int a, int s, int o, int u);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.jmp = jmp; v.call = call; v.ret = ret;
    v.rel = rel; v.op = op; v.flags = flags; v.target = target;
    v.e_addr = a; v.e_sp = s; v.e_ovf = o; v.e_unf = u;
    vecs.push_back(v);
  endfunction

  initial begin
    RST_N = 0; EN = 0; JMP_INST = 0; CALL_INST = 0; RET_INST = 0; REL = 0;
    OP = '0; FLAGS = '0; TARGET = '0;
    m_addr = 0; m_ovf = 0; m_unf = 0;

    //   rst en jmp cal ret rel op       flags  tgt    addr sp ovf unf
    add(0, 1, 0, 1, 0, 0, 4'b0000, 8'h00, 8'h33, 'hF0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 4'b0111, 8'h00, 8'h44, 'hF0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 4'b0111, 8'h00, 8'h10, 'h10, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 4'b1010, 8'h04, 8'h40, 'h40, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 4'b0111, 8'h00, 8'h10, 'h10, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 4'b0010, 8'h04, 8'h40, 'h11, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 4'b0111, 8'h00, 8'h20, 'h20, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1, 4'b0111, 8'h00, 8'hFC, 'h1C, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 4'b0111, 8'h00, 8'hFE, 'hFE, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1, 4'b0111, 8'h00, 8'h05, 'h03, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 4'b0111, 8'h00, 8'h10, 'h10, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 4'b0000, 8'h00, 8'h50, 'h50, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0, 4'b0000, 8'h00, 8'h80, 'h80, 2, 0, 0);
    add(1, 1, 0, 0, 1, 0, 4'b0000, 8'h00, 8'h00, 'h51, 1, 0, 0);
    add(1, 1, 0, 0, 1, 0, 4'b0000, 8'h00, 8'h00, 'h11, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 4'b0000, 8'h00, 8'h00, 'h12, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 4'b0000, 8'h00, 8'h00, 'h13, 0, 0, 1);
    add(1, 1, 0, 1, 0, 1, 4'b0000, 8'h00, 8'h00, 'h13, 1, 0, 1);
    add(1, 1, 1, 1, 1, 0, 4'b0111, 8'h00, 8'h77, 'h14, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 4'b0000, 8'h00, 8'h60, 'h14, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 4'b0000, 8'h00, 8'h00, 'hF0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].jmp, vecs[i].call,
            vecs[i].ret, vecs[i].rel, vecs[i].op, vecs[i].flags, vecs[i].target);
      check_exp($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_sp,
                vecs[i].e_ovf, vecs[i].e_unf);
    end

    // reset two cycles then sequential run through the wrap
    drive(0, 1, 0, 0, 0, 0, 4'h0, 8'h00, 8'h00);
    drive(0, 1, 0, 0, 0, 0, 4'h0, 8'h00, 8'h00);
    check_exp("reset", 'hF0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, 0, 0, 4'h0, 8'h00, 8'h00);
      check_model($sformatf("seq%0d", i));
    end
    check_exp("wrap", 'h00, 0, 0, 0);

    // stall at 0x05 for three cycles with strobes ignored
    go_to(8'h05);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 1, 1, 0, 4'b0111, 8'h00, 8'h99);
      check_exp($sformatf("stall%0d", i), 'h05, 0, 0, 0);
    end

    // five CALLs (fifth overflows), four good RETs, fifth RET underflows
    go_to(8'h10);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 1, 0, 0, 4'h0, 8'h00, 8'((i + 2) * 16));
      check_model($sformatf("call%0d", i));
    end
    check_exp("ovf", 'h51, 4, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 1, 0, 4'h0, 8'h00, 8'h00);
      check_model($sformatf("ret%0d", i));
    end
    check_exp("unf", 'h12, 0, 1, 1);

    // reset arriving together with a CALL while errors and stack are live
    drive(1, 1, 0, 1, 0, 0, 4'h0, 8'h00, 8'h30);
    drive(1, 1, 0, 1, 0, 0, 4'h0, 8'h00, 8'h40);
    drive(0, 1, 0, 1, 0, 0, 4'h0, 8'h00, 8'h50);
    check_exp("rst_call", 'hF0, 0, 0, 0);

    // random run against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            4'($urandom), 8'($urandom), 8'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program-counter and branch unit for the next-generation core.
- Replaces the fixed 8-bit increment/parallel-load instruction pointer.
- Adds the following features:
  - configurable address width;
  - absolute and PC-relative conditional jumps;
  - a hardware return-address stack for CALL/RET;
  - stall;
  - synchronous reset;
  - sticky stack-error flags.
- Sits between the instruction decoder (JMP_INST/CALL_INST/RET_INST, OP, TARGET), the ALU flag register (FLAGS) and instruction memory (ADDR).

Parameters:
- AW, 8: width of the program address, TARGET and stack entries.
- DEPTH, 4: number of return-stack entries (>=1).
- RESET_ADDR, 0: value loaded into ADDR on reset.

Ports:
- CLK  input  1: single clock; all state updates on rising edge.
- RST_N  input  1: synchronous active-low reset.
- EN  input  1: advance enable; 0 = stall, all state held.
- JMP_INST  input  1: conditional jump this cycle.
- CALL_INST  input  1: unconditional call this cycle.
- RET_INST  input  1: return this cycle.
- REL  input  1: 1 = target is ADDR + TARGET (TARGET two's complement); 0 = target is TARGET.
- OP  input  4: jump condition. OP[2:0] selects FLAGS bit; OP[3] is the required value of that bit.
- FLAGS  input  8: ALU flag register.
- TARGET  input  AW: absolute address or signed offset.
- ADDR  output  AW: current program address (registered).
- SP  output  clog2(DEPTH+1): number of valid stack entries.
- STK_FULL  output  1: SP == DEPTH (combinational from SP).
- STK_EMPTY  output  1: SP == 0 (combinational from SP).
- OVF_ERR  output  1: sticky; CALL attempted with stack full.
- UNF_ERR  output  1: sticky; RET attempted with stack empty.

Behaviour:
- Reset:
  - When RST_N == 0 at a rising edge: ADDR <= RESET_ADDR, SP <= 0, OVF_ERR <= 0, UNF_ERR <= 0.
  - Stack RAM contents are not cleared and are unobservable.
  - Reset overrides EN and all instructions, including mid-call/return.
- Stall: EN == 0 holds ADDR, SP, stack contents and error flags; instruction inputs are ignored.
- Next-address computation:
  - NXT = ADDR + 1 mod 2^AW; wraps from 2^AW-1 to 0.
  - TGT = REL ? (ADDR + sign-extended TARGET) mod 2^AW : TARGET.
- Jump condition: COND = (FLAGS[OP[2:0]] == OP[3]).
- Priority when EN == 1: RET > CALL > JMP > sequential. Lower-priority instruction strobes in the same cycle are ignored.
- RET:
  - If SP > 0: ADDR <= stack[SP-1], SP <= SP-1.
  - Else: UNF_ERR <= 1, ADDR <= NXT, SP unchanged.
- CALL:
  - If SP < DEPTH: stack[SP] <= NXT, SP <= SP+1, ADDR <= TGT.
  - Else: OVF_ERR <= 1, ADDR <= NXT, stack unchanged.
- JMP:
  - ADDR <= COND ? TGT : NXT.
  - SP unchanged.
  - OP is ignored for CALL/RET.
- No instruction: ADDR <= NXT.
- Latency:
  - Every decision takes effect on ADDR one edge after the inputs are sampled.
  - No delay slots.
  - The fetch in the cycle after a taken branch uses the new ADDR.
- Relative addressing: REL == 1 with TARGET == 0 on a taken jump/call holds ADDR at its current value (tight loop); this is legal.
- Error flags:
  - Clear only on reset.
  - Setting an error never corrupts SP or stack contents.
- Stack storage: DEPTH x AW register array, written only on a successful CALL.

Test Plan:
- Reset, sequential wrap, stall:
  - AW=8, RESET_ADDR=0xF0, RST_N low 2 cycles, then EN=1 with no instructions: ADDR 0xF0, 0xF1 … 0xFF, 0x00.
  - EN=0 for 3 cycles at 0x05 → ADDR stays 0x05.
- Conditional jump, both polarities:
  - FLAGS=0x04, OP=4'b1010, JMP, TARGET=0x40, REL=0 at ADDR 0x10 → ADDR 0x40.
  - Same with OP=4'b0010 → ADDR 0x11.
- Relative jump:
  - ADDR 0x20, REL=1, TARGET=0xFC, taken → ADDR 0x1C.
  - ADDR 0xFE, TARGET=0x05 → ADDR 0x03.
- Nested call/return:
  - CALL at 0x10 (T=0x50), CALL at 0x50 (T=0x80) → SP 2.
  - RET → ADDR 0x51, SP 1; RET → ADDR 0x11, SP 0, STK_EMPTY=1.
- Overflow/underflow (DEPTH=4):
  - 5 consecutive CALLs → 5th leaves SP=4, ADDR=NXT, OVF_ERR=1.
  - 4 RETs return the correct addresses.
  - A 5th RET → UNF_ERR=1, ADDR=NXT, SP=0.
- Priority and reset mid-operation:
  - RET+CALL+JMP asserted together with SP=1 → RET wins, SP 0.
  - RST_N low in the same cycle as CALL → ADDR=RESET_ADDR, SP=0, errors clear.
